// File: rtl/ahbl_imem_slv_if.sv
// AHB-Lite instruction-side bus between the core's master port and ahbl_imem_slv.
// Signal names are written from the slave's point of view (i_ = into the slave).
interface ahbl_imem_slv_if;
    logic        i_Ihsel;
    logic [31:0] i_Ihaddr;
    logic        i_Ihwrite;
    logic [3:0]  i_Ihprot;
    logic [2:0]  i_Ihsize;
    logic [2:0]  i_Ihburst;
    logic [1:0]  i_Ihtrans;
    logic        i_Ihmastlock;
    logic [31:0] i_Ihwdata;
    logic        i_Ihreadyin;
    logic [31:0] o_Ihrdata;
    logic        o_Ihreadyout;
    logic        o_Ihresp;

    modport master (
        output i_Ihsel, i_Ihaddr, i_Ihwrite, i_Ihprot, i_Ihsize, i_Ihburst,
        output i_Ihtrans, i_Ihmastlock, i_Ihwdata, i_Ihreadyin,
        input  o_Ihrdata, o_Ihreadyout, o_Ihresp
    );

    modport slave (
        input  i_Ihsel, i_Ihaddr, i_Ihwrite, i_Ihprot, i_Ihsize, i_Ihburst,
        input  i_Ihtrans, i_Ihmastlock, i_Ihwdata, i_Ihreadyin,
        output o_Ihrdata, o_Ihreadyout, o_Ihresp
    );
endinterface

// File: rtl/ahbl_imem_slv.sv
// AHB-Lite instruction memory slave: pipelined address/data phases, programmable
// wait states, two-cycle ERROR response and a sideband preload port.
module ahbl_imem_slv #(
    parameter int  MEM_DEPTH = 1024,
    parameter int  WAIT_CYC  = 0,
    parameter int  RO        = 1,
    localparam int IW        = $clog2(MEM_DEPTH)
) (
    input  logic          i_Clk,
    input  logic          i_RstN,
    ahbl_imem_slv_if.slave ahb,
    input  logic          i_LdEn,
    input  logic [IW-1:0] i_LdAddr,
    input  logic [31:0]   i_LdData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic [IW-1:0] idx_reg;
    logic          wr_pend_reg;
    logic [31:0]   rdata_reg;
    logic [31:0]   mem [MEM_DEPTH];

    logic [IW-1:0] addr_idx;
    logic          phase_end;
    logic          accept;
    logic          addr_err;
    logic          accept_ok;
    logic          commit_we;
    logic          fwd_hit;
    logic          readyout;
    logic          resp;

    // Protection, burst and lock attributes play no part in decoding.
    logic unused_attr;
    assign unused_attr = ^{ahb.i_Ihprot, ahb.i_Ihburst, ahb.i_Ihmastlock, ahb.i_Ihtrans[0]};

    assign addr_idx  = ahb.i_Ihaddr[IW+1:2];
    // A new address phase may only be taken while our own data phase is completing.
    assign phase_end = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
    assign accept    = phase_end && ahb.i_Ihsel && ahb.i_Ihreadyin && ahb.i_Ihtrans[1];
    assign addr_err  = (ahb.i_Ihsize != 3'b010)
                    || (ahb.i_Ihaddr[1:0] != 2'b00)
                    || (ahb.i_Ihaddr[31:IW+2] != '0)
                    || (ahb.i_Ihwrite && (RO != 0));
    assign accept_ok = accept && !addr_err;

    // Write data is only on the bus in the final data-phase cycle; a reset edge drops it.
    assign commit_we = i_RstN && wr_pend_reg && (state_reg == ST_IDLE);
    assign fwd_hit   = commit_we && (idx_reg == addr_idx);

    always_ff @(posedge i_Clk) begin
        if (!i_RstN) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                if (accept && addr_err) begin
                    state_next = ST_ERR1;
                end else if (accept_ok && (WAIT_CYC > 0)) begin
                    state_next = ST_WAIT;
                    cnt_next   = 3'(WAIT_CYC);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        readyout = 1'b1;
        resp     = 1'b0;
        case (state_reg)
            ST_WAIT: readyout = 1'b0;
            ST_ERR1: begin
                readyout = 1'b0;
                resp     = 1'b1;
            end
            ST_ERR2: resp = 1'b1;
            default: ;
        endcase
    end

    assign ahb.o_Ihreadyout = readyout;
    assign ahb.o_Ihresp     = resp;
    assign ahb.o_Ihrdata    = rdata_reg;

    always_ff @(posedge i_Clk) begin
        if (!i_RstN) begin
            idx_reg     <= '0;
            wr_pend_reg <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            if (phase_end) begin
                wr_pend_reg <= accept_ok && ahb.i_Ihwrite;
            end
            if (accept_ok) begin
                idx_reg <= addr_idx;
            end
            // Read data is fetched at the accept edge and held through the wait states.
            if (accept_ok && !ahb.i_Ihwrite) begin
                rdata_reg <= fwd_hit ? ahb.i_Ihwdata : mem[addr_idx];
            end
        end
    end

    // Bus write is written last so it overrides a preload to the same word.
    always_ff @(posedge i_Clk) begin
        if (i_LdEn) begin
            mem[i_LdAddr] <= i_LdData;
        end
        if (commit_we) begin
            mem[idx_reg] <= ahb.i_Ihwdata;
        end
    end

endmodule
